// File: rtl/score_keeper.sv
// score_keeper: accumulates the player's score from per-note judgement events
// and owns the combo / max-combo counters. A three-state game FSM
// (idle, play, done) decides which judgements count.
//
// Optional feature macro: FEVER_MODE_EN. When defined, hit points are doubled
// while the pre-hit combo is 50 or more.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   game_start   pulse: clear score/combo/max_combo and enter play
//   game_over    pulse: end the run (play -> done)
//   judge_valid  pulse: judge_grade is valid this cycle
//   judge_grade  0 = miss, 1 = good, 2 = great, 3 = perfect
//   score        registered running score, 0..SCORE_MAX
//   combo        current consecutive non-miss count, saturating
//   max_combo    highest combo reached this run
//   playing      high in play
//   done         high in done
module score_keeper #(
  parameter int unsigned SCORE_MAX   = 9999,
  parameter int unsigned PTS_PERFECT = 10,
  parameter int unsigned PTS_GREAT   = 7,
  parameter int unsigned PTS_GOOD    = 4,
  parameter int unsigned COMBO_MAX   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        judge_valid,
  input  logic [1:0]  judge_grade,
  output logic [14:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic        playing,
  output logic        done
);

  localparam logic [15:0] ScoreMax    = 16'(SCORE_MAX);
  localparam logic [7:0]  ComboMax    = 8'(COMBO_MAX);
  localparam logic [5:0]  PtsPerfect  = 6'(PTS_PERFECT);
  localparam logic [5:0]  PtsGreat    = 6'(PTS_GREAT);
  localparam logic [5:0]  PtsGood     = 6'(PTS_GOOD);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic [7:0]  max_q, max_d;

  // Hit arithmetic, all based on the combo value before the current hit.
  logic [5:0]  base_pts;
  logic [5:0]  bonus_pts;
  logic [5:0]  points;
  logic [15:0] score_sum;
  logic [7:0]  combo_inc;

  always_comb begin
    base_pts = PtsGood;
    case (judge_grade)
      2'd3:    base_pts = PtsPerfect;
      2'd2:    base_pts = PtsGreat;
      default: base_pts = PtsGood;
    endcase

    bonus_pts = 6'd0;
    if (combo_q >= 8'd50) begin
      bonus_pts = 6'd5;
    end else if (combo_q >= 8'd10) begin
      bonus_pts = 6'd2;
    end

    points = base_pts + bonus_pts;
`ifdef FEVER_MODE_EN
    if (combo_q >= 8'd50) begin
      points = points << 1;
    end
`endif

    // 16-bit sum so a near-ceiling score can never wrap before the clamp.
    score_sum = {1'b0, score_q} + {10'd0, points};
    combo_inc = (combo_q >= ComboMax) ? ComboMax : combo_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    combo_d = combo_q;
    max_d   = max_q;

    if (game_start) begin
      // Start wins over any judgement or game_over in the same cycle.
      state_d = StPlay;
      score_d = 15'd0;
      combo_d = 8'd0;
      max_d   = 8'd0;
    end else begin
      case (state_q)
        StPlay: begin
          if (judge_valid) begin
            if (judge_grade == 2'd0) begin
              combo_d = 8'd0;
            end else begin
              combo_d = combo_inc;
              if (combo_inc > max_q) begin
                max_d = combo_inc;
              end
              score_d = (score_sum > ScoreMax) ? ScoreMax[14:0] : score_sum[14:0];
            end
          end
          // A judgement in the same cycle is still applied above.
          if (game_over) begin
            state_d = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      score_q <= 15'd0;
      combo_q <= 8'd0;
      max_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
    end
  end

  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_q;
  assign playing   = (state_q == StPlay);
  assign done      = (state_q == StDone);

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Accumulates the player's score from per-note judgement events and owns the combo and max-combo counters.
- Sits directly upstream of the score display stage. Its registered 15-bit score, 0..9999, feeds the BCD/7-segment display path unchanged.
- A small game FSM gates which judgements count.

Parameters:
- SCORE_MAX, 9999, saturation ceiling of score. Must fit in 15 bits.
- PTS_PERFECT, 10, base points for a perfect hit.
- PTS_GREAT, 7, base points for a great hit.
- PTS_GOOD, 4, base points for a good hit.
- COMBO_MAX, 255, saturation ceiling of combo and max_combo.

Ports:
- clk  in  1  system clock, also used by the judgement logic.
- rst  in  1  asynchronous reset, active-high.
- game_start  in  1  one-cycle pulse; clears the run and enters PLAY.
- game_over  in  1  one-cycle pulse; ends the run.
- judge_valid  in  1  one-cycle pulse; judge_grade is valid.
- judge_grade  in  2  0 = miss, 1 = good, 2 = great, 3 = perfect.
- score  out  15  registered running score, 0..SCORE_MAX.
- combo  out  8  current consecutive non-miss count.
- max_combo  out  8  highest combo reached this run.
- playing  out  1  high in PLAY.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - score = 0, combo = 0, max_combo = 0.
  - playing = 0, done = 0.
- FSM states:
  - IDLE: game_start -> PLAY.
  - PLAY: game_over -> DONE.
  - DONE: game_start -> PLAY.
  - All other inputs hold the current state.
- game_start, in any state: clears score, combo and max_combo and enters PLAY on the next edge.
- game_start has priority over judge_valid and game_over in the same cycle; those inputs are dropped.
- judge_valid is accepted only in PLAY. It is ignored in IDLE and DONE, with no output change.
- Latency: one cycle. Outputs reflect an accepted judgement on the clock edge where judge_valid=1 was sampled. Back-to-back pulses on consecutive cycles are each counted.
- Miss (grade 0): combo <= 0. Score and max_combo unchanged.
- Hit (grade 1..3), using the combo value before this hit (c):
  - points = base(grade) + bonus.
  - bonus = 0 if c < 10; 2 if 10 <= c < 50; 5 if c >= 50.
- Hit updates:
  - combo <= min(c+1, COMBO_MAX).
  - max_combo <= max(max_combo, new combo).
- Score arithmetic:
  - Compute score + points in 16 bits.
  - If the result is > SCORE_MAX, score <= SCORE_MAX (saturate, never wrap); otherwise score <= sum.
- Simultaneous judge_valid and game_over in PLAY: the judgement is applied, then the state is DONE on the same edge.
- In DONE all counters freeze until game_start or rst.
- Reset mid-run: all outputs return to reset values immediately, regardless of state.
- playing and done are decoded from the registered state, so they are glitch-free.

Optional Feature:
- FEVER_MODE_EN.
- Defined: when c >= 50, points are doubled, i.e. (base + bonus) << 1, before saturation. Perfect at c >= 50 therefore adds 30.
- Undefined: no doubling; perfect at c >= 50 adds 15.
- The macro has no other effect.

Test Plan:
- Reset/idle: rst pulse, then judge_valid grade 3 in IDLE -> score=0, combo=0, playing=0, done=0.
- Basic sequence: game_start, then grades 3, 2, 1 -> score 10, 17, 21 on successive cycles; combo=3, max_combo=3.
- Combo bonus: 10 perfects, then 1 perfect -> score=100, then 112 (c=10, bonus 2). A miss afterwards -> combo=0, max_combo=11, score=112.
- High combo: 50 consecutive perfects, then 1 perfect -> 51st adds 15 (FEVER_MODE_EN off) or 30 (on).
- Saturation: preload near 9995 via hits, then perfect -> score=9999; further hits hold 9999 with no wrap to a small value.
- Simultaneity: judge_valid(3)+game_over same cycle at score 40 -> score=50 or more and done=1; then judge_valid -> no change. game_start+judge_valid same cycle -> score=0, playing=1.
